// File: rtl/audio_noise_pkg.sv
// Shared constants, tap layout and config selector for the multi-channel noise source.
package audio_noise_pkg;

  localparam int LFSR_W = 23;
  localparam logic [LFSR_W-1:0] SEED_DEF = 23'h7FFFF8;

  // Output taps, MSB first
  localparam int TAPS [8] = '{22, 20, 16, 13, 11, 7, 4, 2};

  typedef enum logic [1:0] {
    CFG_FREQ = 2'd0,
    CFG_CTRL = 2'd1,
    CFG_SEED = 2'd2,
    CFG_RSVD = 2'd3
  } cfg_sel_e;

  function automatic logic [7:0] lfsr_taps(input logic [LFSR_W-1:0] s);
    logic [7:0] t;
    t = '0;
    for (int i = 0; i < 8; i++) t[7-i] = s[TAPS[i]];
    return t;
  endfunction

endpackage

// File: rtl/audio_noise_ch.sv
// One noise channel: phase accumulator, 23-bit LFSR (long/short), enable gate, output register.
module audio_noise_ch
  import audio_noise_pkg::*;
#(
  parameter int FREQ_W = 16,
  parameter int ACC_W  = 19,
  parameter int OUT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              wr_i,
  input  logic [1:0]        sel_i,
  input  logic [22:0]       data_i,
  output logic              step_o,
  output logic [OUT_W-1:0]  sample_o
);

  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              en_q, en_d;
  logic              short_q, short_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [22:0]       lfsr_q, lfsr_d;
  logic              step_q, step_d;
  logic [OUT_W-1:0]  sample_q, sample_d;

  logic [ACC_W:0]    sum;
  logic              carry;
  logic              fb;
  logic [7:0]        taps;
  cfg_sel_e          sel;

  always_comb begin
    sel      = cfg_sel_e'(sel_i);
    sum      = {1'b0, acc_q} + (ACC_W+1)'(freq_q);
    carry    = en_q & sum[ACC_W];
    fb       = short_q ? (lfsr_q[6] ^ lfsr_q[5]) : (lfsr_q[22] ^ lfsr_q[17]);
    taps     = lfsr_taps(lfsr_q);

    freq_d   = freq_q;
    en_d     = en_q;
    short_d  = short_q;
    acc_d    = en_q ? sum[ACC_W-1:0] : acc_q;
    lfsr_d   = lfsr_q;
    step_d   = carry;
    sample_d = en_q ? taps[7 -: OUT_W] : '0;

    // All-zero state is a lock-up; reload the default seed instead of shifting
    if (carry) lfsr_d = (lfsr_q == '0) ? SEED_DEF : {lfsr_q[21:0], fb};

    // A seed write overrides any carry on the same edge, including its step pulse
    if (wr_i) begin
      unique case (sel)
        CFG_FREQ: freq_d = data_i[FREQ_W-1:0];
        CFG_CTRL: begin
          en_d    = data_i[1];
          short_d = data_i[0];
        end
        CFG_SEED: begin
          lfsr_d = (data_i == '0) ? SEED_DEF : data_i;
          acc_d  = '0;
          step_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      freq_q   <= '0;
      en_q     <= 1'b0;
      short_q  <= 1'b0;
      acc_q    <= '0;
      lfsr_q   <= SEED_DEF;
      step_q   <= 1'b0;
      sample_q <= '0;
    end else begin
      freq_q   <= freq_d;
      en_q     <= en_d;
      short_q  <= short_d;
      acc_q    <= acc_d;
      lfsr_q   <= lfsr_d;
      step_q   <= step_d;
      sample_q <= sample_d;
    end
  end

  assign step_o   = step_q;
  assign sample_o = sample_q;

endmodule

// File: rtl/audio_noise_mc.sv
// Multi-channel SID-style noise source: config write decode plus NUM_CH channel instances.
module audio_noise_mc
  import audio_noise_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int FREQ_W = 16,
  parameter int ACC_W  = 19,
  parameter int OUT_W  = 8,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    cfg_we_i,
  input  logic [CH_W-1:0]         cfg_ch_i,
  input  logic [1:0]              cfg_sel_i,
  input  logic [LFSR_W-1:0]       cfg_data_i,
  output logic [NUM_CH-1:0]       step_o,
  output logic [NUM_CH*OUT_W-1:0] sample_data_o
);

  // Channel indices with no instance never match, so such writes fall on the floor
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic wr;
    assign wr = cfg_we_i && (cfg_ch_i == CH_W'(c));

    audio_noise_ch #(
      .FREQ_W (FREQ_W),
      .ACC_W  (ACC_W),
      .OUT_W  (OUT_W)
    ) u_ch (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .wr_i     (wr),
      .sel_i    (cfg_sel_i),
      .data_i   (cfg_data_i),
      .step_o   (step_o[c]),
      .sample_o (sample_data_o[c*OUT_W +: OUT_W])
    );
  end

endmodule
